// File: rtl/eio_bridge_pkg.sv
// eio_bridge_pkg: register map, isolation state encoding and STAT layout for the embedded I/O bridge
package eio_bridge_pkg;
  localparam logic [2:0] A_TX   = 3'd0;
  localparam logic [2:0] A_RX   = 3'd1;
  localparam logic [2:0] A_DIR  = 3'd2;
  localparam logic [2:0] A_PEND = 3'd3;
  localparam logic [2:0] A_MASK = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  typedef enum logic [1:0] {ISOL = 2'd0, WAIT = 2'd1, RUN = 2'd2} state_t;
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_ISOL_N    = 2;
  localparam int STAT_EDGE_EN   = 3;
endpackage

// File: rtl/eio_sync.sv
// eio_sync: W-wide, STAGES-deep resettable flop chain for fabric-driven signals
module eio_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] stage_q [STAGES];
  logic [W-1:0] stage_d [STAGES];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) stage_q[i] <= reset ? '0 : stage_d[i];
  end
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/soc_eio_bridge.sv
// soc_eio_bridge: SoC-side register port, isolation release sequencer and edge-capture for the fabric I/O array
module soc_eio_bridge
  import eio_bridge_pkg::*;
#(
  parameter int NUM_IO      = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CONFIG_DONE,
  input  logic [NUM_IO-1:0] SOC_OUT,
  input  logic [NUM_IO-1:0] SOC_DIR,
  output logic [NUM_IO-1:0] SOC_IN,
  output logic              IO_ISOL_N,
  input  logic              reg_req,
  input  logic              reg_we,
  input  logic [2:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic              reg_ack,
  output logic [31:0]       reg_rdata,
  output logic              irq
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 2);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [NUM_IO-1:0] out_s, dir_s, out_p_q, out_p_d;
  logic [NUM_IO-1:0] tx_q, tx_d, pend_q, pend_d, mask_q, mask_d;
  logic [31:0] rdata_q, rdata_d, rd_mux, stat;
  logic ack_q, ack_d, irq_q, irq_d, isol_n, edge_en, wr;
  logic unused_wdata;

  eio_sync #(.W(NUM_IO), .STAGES(SYNC_STAGES)) u_sync_out (
    .clk(clk), .reset(reset), .d(SOC_OUT), .q(out_s)
  );
  eio_sync #(.W(NUM_IO), .STAGES(SYNC_STAGES)) u_sync_dir (
    .clk(clk), .reset(reset), .d(SOC_DIR), .q(dir_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISOL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Losing CONFIG_DONE in any state drops straight back to isolation
  always_comb begin
    state_d = !CONFIG_DONE ? ISOL :
              state_q == ISOL ? WAIT :
              (state_q == RUN || (state_q == WAIT && cnt_q == CW'(HOLD_CYCLES - 1))) ? RUN : WAIT;
    cnt_d   = (state_q == WAIT && state_d == WAIT) ? cnt_q + CW'(1) : '0;
  end

  always_comb begin
    isol_n   = state_q == RUN;
    edge_en  = settle_q == SW'(SYNC_STAGES + 1);
    settle_d = (state_q == RUN && state_d == RUN) ? (edge_en ? settle_q : settle_q + SW'(1)) : '0;
  end

  always_comb begin
    wr      = reg_req && reg_we;
    out_p_d = out_s;
    tx_d    = (wr && reg_addr == A_TX) ? reg_wdata[NUM_IO-1:0] : tx_q;
    mask_d  = (wr && reg_addr == A_MASK) ? reg_wdata[NUM_IO-1:0] : mask_q;
    // A new rising edge overrides a simultaneous write-one-to-clear
    pend_d  = (pend_q & ~((wr && reg_addr == A_PEND) ? reg_wdata[NUM_IO-1:0] : '0))
            | ({NUM_IO{edge_en}} & ~dir_s & out_s & ~out_p_q);
    irq_d   = |(pend_q & mask_q);
    ack_d   = reg_req;
    stat    = '0;
    stat[STAT_STATE_LSB +: 2] = state_q;
    stat[STAT_ISOL_N]  = isol_n;
    stat[STAT_EDGE_EN] = edge_en;
    rd_mux  = reg_addr == A_TX   ? 32'(tx_q)   :
              reg_addr == A_RX   ? 32'(out_s)  :
              reg_addr == A_DIR  ? 32'(dir_s)  :
              reg_addr == A_PEND ? 32'(pend_q) :
              reg_addr == A_MASK ? 32'(mask_q) :
              reg_addr == A_STAT ? stat : '0;
    rdata_d = (reg_req && !reg_we) ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q <= '0;
      out_p_q  <= '0;
      tx_q     <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      settle_q <= settle_d;
      out_p_q  <= out_p_d;
      tx_q     <= tx_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign unused_wdata = ^reg_wdata;
  assign SOC_IN    = tx_q;
  assign IO_ISOL_N = isol_n;
  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign irq       = irq_q;
endmodule
